// File: rtl/t_sram_responder.sv
// rtl/t_sram_responder.sv - SRAM-side T-row responder: loads T, serves and stores packed words in circular order
module t_sram_responder #(
    parameter int GROUP_BITS  = 24,
    parameter int T_PER_WORD  = 4,
    parameter int HEADER_BITS = 4,
    parameter int WORD_BITS   = HEADER_BITS + GROUP_BITS * T_PER_WORD,
    parameter int DEPTH       = 256,
    parameter int ADDR_BITS   = 8,
    parameter int T_SIZE_BITS = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [T_SIZE_BITS-1:0] i_T_size,
    input  logic                   i_load_start,
    input  logic                   i_load_valid,
    input  logic [1:0]             i_load_t,
    output logic                   o_load_ready,
    input  logic                   i_sram_request,
    output logic [WORD_BITS-1:0]   o_request_data,
    input  logic                   i_sram_send,
    input  logic [WORD_BITS-1:0]   i_send_data,
    input  logic                   i_sram_init,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int PAYLOAD_BITS = GROUP_BITS * T_PER_WORD;
    localparam int CNT_BITS     = HEADER_BITS - 1;
    localparam int PACK_BITS    = (T_PER_WORD > 1) ? $clog2(T_PER_WORD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PACK_BITS-1:0]    pack_cnt_q, pack_cnt_d;
    logic [T_SIZE_BITS-1:0]  char_cnt_q, char_cnt_d;
    logic [PAYLOAD_BITS-1:0] pack_q, pack_d;
    logic [WORD_BITS-1:0]    resp_q, resp_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic                    mem_we;
    logic [ADDR_BITS-1:0]    mem_addr;
    logic [PAYLOAD_BITS-1:0] mem_wdata;

    logic [T_SIZE_BITS:0]    nw_full;
    logic [T_SIZE_BITS:0]    nw_m1_full;
    logic                    last_nz;
    logic                    rd_last;
    logic                    wr_last;
    logic [CNT_BITS-1:0]     rd_cnt;
    logic                    last_char;
    logic                    unused_hdr;

    assign unused_hdr = ^i_send_data[WORD_BITS-1:PAYLOAD_BITS];

    // Word-count arithmetic is one bit wider so that NW = DEPTH does not overflow.
    assign nw_full    = ({1'b0, i_T_size} + (T_SIZE_BITS+1)'(T_PER_WORD - 1))
                        / (T_SIZE_BITS+1)'(T_PER_WORD);
    assign nw_m1_full = nw_full - (T_SIZE_BITS+1)'(1);
    assign last_nz    = (i_T_size % T_SIZE_BITS'(T_PER_WORD)) != '0;
    assign rd_last    = (T_SIZE_BITS+1)'(rd_ptr_q) == nw_m1_full;
    assign wr_last    = (T_SIZE_BITS+1)'(wr_ptr_q) == nw_m1_full;
    assign rd_cnt     = (rd_last && last_nz) ? CNT_BITS'(i_T_size % T_SIZE_BITS'(T_PER_WORD))
                                             : '0;
    assign last_char  = char_cnt_q == (i_T_size - T_SIZE_BITS'(1));

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pack_cnt_d = pack_cnt_q;
        char_cnt_d = char_cnt_q;
        pack_d     = pack_q;
        resp_d     = {1'b0, resp_q[WORD_BITS-2:0]};
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = wr_ptr_q;
        mem_wdata  = i_send_data[PAYLOAD_BITS-1:0];

        case (state_q)
            S_IDLE: begin
                if (i_load_start) begin
                    state_d    = S_LOAD;
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    pack_cnt_d = '0;
                    char_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (i_load_valid) begin
                    pack_d[PAYLOAD_BITS-1-GROUP_BITS*int'(pack_cnt_q) -: GROUP_BITS] =
                        {i_load_t, {(GROUP_BITS-2){1'b0}}};
                    char_cnt_d = char_cnt_q + T_SIZE_BITS'(1);
                    pack_cnt_d = pack_cnt_q + PACK_BITS'(1);
                    if (pack_cnt_q == PACK_BITS'(T_PER_WORD - 1) || last_char) begin
                        mem_we    = 1'b1;
                        mem_wdata = pack_d;
                        // Slots beyond the incoming group are padding in a partial word.
                        for (int k = 0; k < T_PER_WORD; k++) begin
                            if (k > int'(pack_cnt_q)) begin
                                mem_wdata[GROUP_BITS*(T_PER_WORD-k)-1 -: GROUP_BITS] = '1;
                            end
                        end
                        wr_ptr_d   = wr_ptr_q + ADDR_BITS'(1);
                        pack_cnt_d = '0;
                        if (last_char) begin
                            state_d  = S_SERVE;
                            rd_ptr_d = '0;
                            wr_ptr_d = '0;
                        end
                    end
                end
            end
            S_SERVE: begin
                if (i_sram_request && !resp_q[WORD_BITS-1] && !i_sram_init) begin
                    resp_d   = {1'b1, rd_cnt, mem[rd_ptr_q]};
                    rd_ptr_d = rd_last ? '0 : rd_ptr_q + ADDR_BITS'(1);
                end
                if (i_sram_send) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_last ? '0 : wr_ptr_q + ADDR_BITS'(1);
                end
                if (i_sram_init) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pack_cnt_q <= '0;
            char_cnt_q <= '0;
            pack_q     <= '0;
            resp_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pack_cnt_q <= pack_cnt_d;
            char_cnt_q <= char_cnt_d;
            pack_q     <= pack_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign o_load_ready   = state_q == S_LOAD;
    assign o_request_data = resp_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
endmodule

// File: tb/tb_t_sram_responder.sv
// tb/tb_t_sram_responder.sv - randomized self-checking bench for t_sram_responder
module tb_t_sram_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic [10:0]  i_T_size;
    logic         i_load_start;
    logic         i_load_valid;
    logic [1:0]   i_load_t;
    logic         o_load_ready;
    logic         i_sram_request;
    logic [99:0]  o_request_data;
    logic         i_sram_send;
    logic [99:0]  i_send_data;
    logic         i_sram_init;
    logic         o_busy;
    logic         o_done;

    int total = 0;
    int bad   = 0;

    // Reference state: T characters, word image, and serving position
    logic [1:0]  m_t [1024];
    logic [95:0] exp_mem [256];
    int          m_T, m_nw, m_rd, m_wr;
    bit          m_serve, m_valid;
    logic [99:0] m_word;
    logic [99:0] last_resp;

    t_sram_responder dut (
        .clk(clk), .rst(rst), .i_T_size(i_T_size), .i_load_start(i_load_start),
        .i_load_valid(i_load_valid), .i_load_t(i_load_t), .o_load_ready(o_load_ready),
        .i_sram_request(i_sram_request), .o_request_data(o_request_data),
        .i_sram_send(i_sram_send), .i_send_data(i_send_data), .i_sram_init(i_sram_init),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [99:0] got, input logic [99:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] model_word(input int w);
        logic [95:0] p;
        for (int k = 0; k < 4; k++) begin
            if (4 * w + k < m_T) p[24*(4-k)-1 -: 24] = {m_t[4*w+k], 22'd0};
            else                 p[24*(4-k)-1 -: 24] = 24'hFFFFFF;
        end
        return p;
    endfunction

    function automatic logic [2:0] model_cnt(input int rd);
        if (rd == m_nw - 1 && (m_T % 4) != 0) return 3'(m_T % 4);
        return 3'd0;
    endfunction

    function automatic logic [99:0] rand_word();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[99:0];
    endfunction

    task automatic tick(input logic req, input logic snd, input logic [99:0] data, input logic ini);
        bit acc, exp_done;
        i_sram_request = req;
        i_sram_send    = snd;
        i_send_data    = data;
        i_sram_init    = ini;
        acc      = m_serve && req && !m_valid && !ini;
        exp_done = m_serve && ini;
        if (acc) begin
            m_word = {1'b1, model_cnt(m_rd), exp_mem[m_rd]};
            m_rd   = (m_rd + 1) % m_nw;
        end
        if (m_serve && snd) begin
            exp_mem[m_wr] = data[95:0];
            m_wr          = (m_wr + 1) % m_nw;
        end
        if (m_serve && ini) m_serve = 0;
        m_valid = acc;
        @(posedge clk);
        #1;
        expect_eq("valid", o_request_data[99], m_valid);
        if (m_valid) begin
            expect_eq("resp", o_request_data, m_word);
            last_resp = o_request_data;
        end
        expect_eq("done", o_done, exp_done);
        expect_eq("busy", o_busy, m_serve);
        i_sram_request = 0;
        i_sram_send    = 0;
        i_sram_init    = 0;
    endtask

    // Loads m_t[0..tsz-1]; when stop < tsz, reset is asserted after that many characters.
    task automatic load_t(input int tsz, input int stop);
        int n;
        n = (stop < tsz) ? stop : tsz;
        i_T_size     = 11'(tsz);
        i_load_start = 1;
        @(posedge clk);
        #1;
        i_load_start = 0;
        expect_eq("load_ready", o_load_ready, 1);
        expect_eq("load_busy", o_busy, 1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_sram_request = 1'($urandom());
                @(posedge clk);
                #1;
            end
            i_load_valid   = 1;
            i_load_t       = m_t[i];
            i_sram_request = 1'($urandom());
            i_sram_send    = 1'($urandom());
            i_send_data    = rand_word();
            @(posedge clk);
            #1;
            i_load_valid   = 0;
            i_sram_request = 0;
            i_sram_send    = 0;
            expect_eq("load_noresp", o_request_data[99], 0);
        end
        if (stop < tsz) begin
            rst = 1;
            @(posedge clk);
            #1;
            rst = 0;
            expect_eq("abort_data", o_request_data, 0);
            expect_eq("abort_flags", {o_busy, o_done, o_load_ready}, 0);
            m_serve = 0;
            m_valid = 0;
        end else begin
            m_T     = tsz;
            m_nw    = (tsz + 3) / 4;
            m_rd    = 0;
            m_wr    = 0;
            m_serve = 1;
            m_valid = 0;
            for (int w = 0; w < m_nw; w++) exp_mem[w] = model_word(w);
            expect_eq("serve_busy", o_busy, 1);
            expect_eq("serve_ready", o_load_ready, 0);
        end
    endtask

    initial begin
        logic [99:0] r0, r1, r2, p, q;
        logic [95:0] w2_exp;
        int nresp, tsz;

        rst = 1; i_T_size = 0; i_load_start = 0; i_load_valid = 0; i_load_t = 0;
        i_sram_request = 0; i_sram_send = 0; i_send_data = 0; i_sram_init = 0;
        m_serve = 0; m_valid = 0; m_T = 1; m_nw = 1; m_rd = 0; m_wr = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_data", o_request_data, 0);
        expect_eq("rst_flags", {o_busy, o_done, o_load_ready}, 0);
        rst = 0;

        // Directed: T = 0,1,2,3,0,1,2,3,0,1
        for (int i = 0; i < 10; i++) m_t[i] = 2'(i % 4);
        load_t(10, 10);
        tick(1, 0, 0, 0); r0 = last_resp; tick(0, 0, 0, 0);
        tick(1, 0, 0, 0); r1 = last_resp; tick(0, 0, 0, 0);
        tick(1, 0, 0, 0); r2 = last_resp; tick(0, 0, 0, 0);
        expect_eq("hdr0", r0[99:96], 4'b1000);
        expect_eq("hdr1", r1[99:96], 4'b1000);
        expect_eq("hdr2", r2[99:96], 4'b1010);
        w2_exp = {2'd0, 22'd0, 2'd1, 22'd0, 48'hFFFF_FFFF_FFFF};
        expect_eq("word2", r2[95:0], w2_exp);
        expect_eq("word0", r0[95:0], {2'd0, 22'd0, 2'd1, 22'd0, 2'd2, 22'd0, 2'd3, 22'd0});

        tick(1, 0, 0, 0); expect_eq("wrap0", last_resp, r0); tick(0, 0, 0, 0);
        tick(1, 0, 0, 0); expect_eq("wrap1", last_resp, r1); tick(0, 0, 0, 0);
        tick(1, 0, 0, 0); expect_eq("wrap2", last_resp, r2); tick(0, 0, 0, 0);

        // Round trip on word 0, then read-first collision on word 1
        tick(1, 0, 0, 0);
        p = r0;
        for (int k = 0; k < 4; k++) p[24*(4-k)-3 -: 22] = {11'd5, 11'd7};
        tick(0, 1, p, 0);
        q = r1;
        for (int k = 0; k < 4; k++) q[24*(4-k)-3 -: 22] = {11'd9, 11'd3};
        tick(1, 1, q, 0);
        expect_eq("collide_old", last_resp, r1);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0); tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        expect_eq("rt_word0", last_resp[95:0], p[95:0]);
        expect_eq("rt_v0", last_resp[93:83], 11'd5);
        expect_eq("rt_f0", last_resp[82:72], 11'd7);
        expect_eq("rt_t", {last_resp[95:94], last_resp[71:70], last_resp[47:46], last_resp[23:22]}, 8'b00_01_10_11);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        expect_eq("collide_new", last_resp[95:0], q[95:0]);
        tick(0, 0, 0, 0);

        // Back-to-back request hold
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0, 0);
            if (o_request_data[99]) nresp++;
        end
        expect_eq("b2b_count", nresp, 3);

        // Exit via init
        tick(0, 0, 0, 1);
        expect_eq("init_done", o_done, 1);
        expect_eq("init_idle", o_busy, 0);
        tick(0, 0, 0, 0);
        expect_eq("done_pulse", o_done, 0);

        // Reset during LOAD after 3 characters
        load_t(10, 3);
        for (int i = 0; i < 4; i++) tick(1, 1, rand_word(), 0);

        // Randomized sessions including boundary sizes
        for (int r = 0; r < 6; r++) begin
            tsz = (r == 0) ? 1 : (r == 1) ? 4 : (r == 2) ? 1024 : $urandom_range(1, 60);
            for (int i = 0; i < tsz; i++) m_t[i] = 2'($urandom());
            load_t(tsz, tsz);
            for (int c = 0; c < 250; c++)
                tick(1'($urandom()), ($urandom_range(0, 2) == 0), rand_word(), 0);
            tick(1'($urandom()), 1'($urandom()), rand_word(), 1);
            tick(0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/t_sram_responder.md
Name: t_sram_responder

Overview:
- SRAM-side responder for the T-row stream used by the data processor when len(T) exceeds the on-chip cache limit.
- Loads the initial T sequence from the top level, then serves one packed word per request and stores each word the processor sends back (updated v/f per column).
- Serves and stores words in circular order across repeated passes over T.
- Sits between the top level and the data processor; it is the other end of the request/send/init word protocol.

Parameters:
- GROUP_BITS, 24, bits per T entry: {t[1:0], v[10:0], f[10:0]}
- T_PER_WORD, 4, T entries per memory word
- HEADER_BITS, 4, response header: {valid, count[HEADER_BITS-2:0]}
- WORD_BITS, 100, HEADER_BITS + GROUP_BITS*T_PER_WORD
- DEPTH, 256, memory words
- ADDR_BITS, 8, log2(DEPTH)
- T_SIZE_BITS, 11, width of T length

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_T_size  in  T_SIZE_BITS  T length; stable from i_load_start until done
- i_load_start  in  1  pulse; begin loading T
- i_load_valid  in  1  one T character presented
- i_load_t  in  2  T character code
- o_load_ready  out  1  high in LOAD state
- i_sram_request  in  1  processor requests the next word
- o_request_data  out  WORD_BITS  response word; MSB = valid
- i_sram_send  in  1  processor sends one word
- i_send_data  in  WORD_BITS  payload in [GROUP_BITS*T_PER_WORD-1:0]; header bits ignored
- i_sram_init  in  1  pulse; final pass finished
- o_busy  out  1  high in LOAD or SERVE
- o_done  out  1  one-cycle pulse when returning to IDLE from SERVE

Behaviour:
- Reset: state=IDLE; rd_ptr=wr_ptr=0; pack_cnt=0; char_cnt=0; all outputs 0, including o_request_data. Memory contents are not reset. Reset mid-LOAD or mid-SERVE aborts immediately.
- Derived values: NW = ceil(i_T_size/T_PER_WORD); LAST = i_T_size mod T_PER_WORD.
- Header count: the response count field = LAST for word NW-1 when LAST != 0, else 0. Count 0 means the word is full.
- Group order: group k (k=0 first in T order) occupies payload bits [GROUP_BITS*(T_PER_WORD-k)-1 -: GROUP_BITS]. Unused groups are all ones.
- States: IDLE, LOAD, SERVE.
- IDLE:
  - i_load_start -> LOAD with pointers and counters cleared.
  - Requests, sends and load data are ignored.
- LOAD:
  - On each i_load_valid, write {i_load_t, 11'd0, 11'd0} into pack register slot pack_cnt.
  - Commit the word to mem[wr_ptr] when pack_cnt==T_PER_WORD-1 or char_cnt==i_T_size-1. Committed word = pack register with the incoming group merged, unused slots ones. On commit, wr_ptr++ and pack_cnt=0.
  - After committing the last character -> SERVE next cycle with rd_ptr=wr_ptr=0.
  - i_sram_request and i_sram_send are ignored.
- SERVE, read:
  - A request is accepted when i_sram_request=1 and o_request_data[MSB]=0 this cycle. Requests made while a response is being driven are dropped; this limits the rate to at most one word per 2 cycles and protects the consumer buffer.
  - Accepted request -> next cycle o_request_data = {1'b1, count(rd_ptr), mem[rd_ptr]} for exactly 1 cycle; otherwise the valid bit is 0 (payload don't-care, held).
  - rd_ptr wraps from NW-1 to 0.
- SERVE, write:
  - i_sram_send writes the i_send_data payload to mem[wr_ptr]; wr_ptr wraps from NW-1 to 0.
  - A read and a write to the same address in one cycle: the read returns the old data (read-first).
- SERVE, exit: i_sram_init -> IDLE next cycle with o_done=1 for 1 cycle.
  - A send in the same cycle as i_sram_init is still written.
  - A request in that cycle is dropped.
- Widths: pointers ADDR_BITS, wrap by compare (not modulo); char_cnt T_SIZE_BITS.
- Range: i_T_size must satisfy 1..DEPTH*T_PER_WORD; behaviour outside this range is undefined.
- o_busy: registered; 1 in LOAD and SERVE.

Test Plan:
- Load packing and partial word: i_T_size=10, load chars 0,1,2,3,0,1,2,3,0,1 -> SERVE. Three requests spaced 2 cycles apart return headers 4'b1000, 4'b1000, 4'b1010; word 2 groups 2..3 are all ones; t fields match, v=f=0.
- Wrap-around: continue with 3 more requests -> words 0,1,2 returned again, identical to the first pass.
- Round trip: after serving word 0, send payload with all v=5, f=7; on the next pass word 0 returns v=5, f=7 and t unchanged.
- Back-to-back requests: i_sram_request held high for 6 cycles -> exactly 3 one-cycle responses on alternating cycles.
- Simultaneous events: request and send at the same address in the same cycle -> response carries the old data; the following pass shows the new data.
- Reset and init: i_sram_init in SERVE -> o_done pulse, then IDLE with o_busy=0. Assert rst during LOAD after 3 chars -> all outputs 0 next cycle, IDLE, and later requests are ignored.
